// File: rtl/freq_meter_if.sv
// rtl/freq_meter_if.sv - measurement request/result bundle for freq_meter
interface freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             start;
  logic             cont_en;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] freq_mhz;
  logic             no_sig;
  logic             ovf;

  modport master (
    output sig_in, start, cont_en,
    input  busy, meas_valid, edge_cnt, freq_mhz, no_sig, ovf
  );

  modport slave (
    input  sig_in, start, cont_en,
    output busy, meas_valid, edge_cnt, freq_mhz, no_sig, ovf
  );
endinterface

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter reporting an async input frequency in MHz
module freq_meter #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int GATE_US      = 4,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  freq_meter_if.slave  bus
);
  localparam int GATE_CYCLES = CLK_FREQ_MHZ * GATE_US;
  localparam int GATE_SHIFT  = $clog2(GATE_US);
  localparam int GC_W        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GC_W-1:0]  GATE_LAST = GC_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [GC_W-1:0]  gate_cnt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             busy_q, meas_valid_q, no_sig_q, ovf_q;
  logic [CNT_W-1:0] edge_cnt_q, freq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Saturating count including the current cycle's rise, so the last gate cycle is counted
  always_comb begin
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (rise) begin
      if (cnt_q == CNT_MAX) ovf_flag_d = 1'b1;
      else                  cnt_d      = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      cnt_q        <= '0;
      ovf_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      edge_cnt_q   <= '0;
      freq_q       <= '0;
      no_sig_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start || bus.cont_en) begin
            state_q    <= GATE;
            gate_cnt_q <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        GATE: begin
          cnt_q      <= cnt_d;
          ovf_flag_q <= ovf_flag_d;
          gate_cnt_q <= gate_cnt_q + GC_W'(1);
          if (gate_cnt_q == GATE_LAST) begin
            state_q      <= LATCH;
            meas_valid_q <= 1'b1;
            edge_cnt_q   <= cnt_d;
            freq_q       <= cnt_d >> GATE_SHIFT;
            no_sig_q     <= (cnt_d == '0);
            ovf_q        <= ovf_flag_d;
          end
        end
        LATCH: begin
          // Rises seen in this cycle are dropped: the one-cycle dead time between windows
          if (bus.cont_en) begin
            state_q    <= GATE;
            gate_cnt_q <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.edge_cnt   = edge_cnt_q;
  assign bus.freq_mhz   = freq_q;
  assign bus.no_sig     = no_sig_q;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter (default and CNT_W=5 instances)
`timescale 1ns/1ps
module tb_freq_meter;
  localparam int GC = 400;

  logic clk;
  logic rst_n;
  logic sig;
  int   sig_half_ns;
  int   cyc;
  int   sig_edges;
  int   n_chk;
  int   n_fail;

  logic start_r [2];
  logic cont_r  [2];
  logic        busy_o [2];
  logic        mv_o   [2];
  logic [15:0] edge_o [2];
  logic [15:0] freq_o [2];
  logic        nosig_o[2];
  logic        ovf_o  [2];

  bit act    [2];
  int st     [2];
  int snap   [2];
  int exp_cnt[2];
  bit m_busy [2];
  bit m_mv   [2];
  int mv_cnt [2];
  int bcnt   [2];

  freq_meter_if #(.CNT_W(16)) bus0 ();
  freq_meter_if #(.CNT_W(5))  bus1 ();

  freq_meter #(.CLK_FREQ_MHZ(100), .GATE_US(4), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  freq_meter #(.CLK_FREQ_MHZ(100), .GATE_US(4), .CNT_W(5)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.sig_in  = sig;
  assign bus1.sig_in  = sig;
  assign bus0.start   = start_r[0];
  assign bus1.start   = start_r[1];
  assign bus0.cont_en = cont_r[0];
  assign bus1.cont_en = cont_r[1];
  assign busy_o[0]  = bus0.busy;
  assign busy_o[1]  = bus1.busy;
  assign mv_o[0]    = bus0.meas_valid;
  assign mv_o[1]    = bus1.meas_valid;
  assign edge_o[0]  = bus0.edge_cnt;
  assign edge_o[1]  = 16'(bus1.edge_cnt);
  assign freq_o[0]  = bus0.freq_mhz;
  assign freq_o[1]  = 16'(bus1.freq_mhz);
  assign nosig_o[0] = bus0.no_sig;
  assign nosig_o[1] = bus1.no_sig;
  assign ovf_o[0]   = bus0.ovf;
  assign ovf_o[1]   = bus1.ovf;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signal edges land on x.3 ns, never on a clock edge
  initial begin
    sig = 1'b0;
    #2.3;
    forever begin
      if (sig_half_ns == 0) #1;
      else begin
        #(sig_half_ns);
        sig = ~sig;
      end
    end
  end

  initial forever begin
    @(posedge sig);
    sig_edges++;
  end

  task automatic chk(input string nm, input longint act_v, input longint req);
    n_chk++;
    if (act_v != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act_v, req);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act_v, input longint lo, input longint hi);
    n_chk++;
    if (act_v < lo || act_v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, act_v, lo, hi);
    end
  endtask

  // Window model: a window opens at the sampling edge, lasts GC edges, reports one edge later
  initial forever begin
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        act[d] = 1'b0;
      end else if (!act[d]) begin
        if (start_r[d] || cont_r[d]) begin
          act[d] = 1'b1; st[d] = cyc; snap[d] = sig_edges;
        end
      end else if (cyc == st[d] + GC) begin
        exp_cnt[d] = sig_edges - snap[d];
      end else if (cyc == st[d] + GC + 1) begin
        if (cont_r[d]) begin
          st[d] = cyc; snap[d] = sig_edges;
        end else begin
          act[d] = 1'b0;
        end
      end
      m_busy[d] = act[d];
      m_mv[d]   = act[d] && (cyc == st[d] + GC);
    end
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      longint e, mx;
      chk($sformatf("busy%0d@%0d", d, cyc), busy_o[d], m_busy[d]);
      chk($sformatf("meas_valid%0d@%0d", d, cyc), mv_o[d], m_mv[d]);
      if (mv_o[d]) mv_cnt[d]++;
      if (busy_o[d]) bcnt[d]++;
      if (mv_o[d] && m_mv[d]) begin
        e  = exp_cnt[d];
        mx = (d == 0) ? 65535 : 31;
        if (e + 1 < mx) begin
          chk_rng($sformatf("edge_cnt%0d model", d), edge_o[d], e - 1, e + 1);
          chk($sformatf("ovf%0d model", d), ovf_o[d], 0);
        end else if (e - 1 > mx) begin
          chk($sformatf("edge_cnt%0d sat", d), edge_o[d], mx);
          chk($sformatf("ovf%0d sat", d), ovf_o[d], 1);
        end
        chk($sformatf("freq%0d rel", d), freq_o[d], edge_o[d] / 4);
        chk($sformatf("no_sig%0d rel", d), nosig_o[d], (edge_o[d] == 0) ? 1 : 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int d, output int k);
    @(negedge clk);
    #1 start_r[d] = 1'b1;
    @(posedge clk);
    #1 k = cyc;
    start_r[d] = 1'b0;
  endtask

  task automatic wait_mv(input int d, output int c);
    c = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (mv_o[d]) begin
        c = cyc;
        break;
      end
    end
    n_chk++;
    if (c < 0) begin
      n_fail++;
      $display("FAIL wait_mv%0d: got no pulse in 2000 cycles, required one", d);
    end
  endtask

  task automatic hold_level(input logic lvl);
    sig_half_ns = 0;
    #150;
    sig = lvl;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int k, c, m, b;
    int t[4];
    rst_n = 1'b0;
    sig_half_ns = 50;
    for (int d = 0; d < 2; d++) begin
      start_r[d] = 1'b0;
      cont_r[d]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst busy%0d", d), busy_o[d], 0);
      chk($sformatf("rst mv%0d", d), mv_o[d], 0);
      chk($sformatf("rst edge%0d", d), edge_o[d], 0);
      chk($sformatf("rst freq%0d", d), freq_o[d], 0);
      chk($sformatf("rst no_sig%0d", d), nosig_o[d], 0);
      chk($sformatf("rst ovf%0d", d), ovf_o[d], 0);
    end
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 10 MHz single shot
    m = mv_cnt[0];
    b = bcnt[0];
    do_start(0, k);
    wait_mv(0, c);
    chk("t1 latency", c + 1 - k, 401);
    chk_rng("t1 edge_cnt", edge_o[0], 39, 41);
    chk((edge_o[0] == 39) ? "t1 freq39" : "t1 freq", freq_o[0], (edge_o[0] == 39) ? 9 : 10);
    chk("t1 no_sig", nosig_o[0], 0);
    chk("t1 ovf", ovf_o[0], 0);
    repeat (500) @(negedge clk);
    chk("t1 pulses", mv_cnt[0] - m, 1);
    chk("t1 busy cycles", bcnt[0] - b, 401);

    // 25 MHz continuous, dropped mid-fourth window
    sig_half_ns = 20;
    repeat (10) @(negedge clk);
    m = mv_cnt[0];
    #1 cont_r[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_mv(0, t[i]);
      chk_rng("t2 edge_cnt", edge_o[0], 99, 101);
      chk((edge_o[0] == 99) ? "t2 freq99" : "t2 freq", freq_o[0], (edge_o[0] == 99) ? 24 : 25);
    end
    chk("t2 spacing1", t[1] - t[0], 401);
    chk("t2 spacing2", t[2] - t[1], 401);
    repeat (150) @(negedge clk);
    #1 cont_r[0] = 1'b0;
    wait_mv(0, t[3]);
    chk("t2 spacing3", t[3] - t[2], 401);
    repeat (2) @(negedge clk);
    chk("t2 busy after", busy_o[0], 0);
    repeat (500) @(negedge clk);
    chk("t2 pulses", mv_cnt[0] - m, 4);

    // Held-high then held-low input
    for (int lv = 1; lv >= 0; lv--) begin
      hold_level(lv[0]);
      do_start(0, k);
      wait_mv(0, c);
      chk($sformatf("t3 edge lvl%0d", lv), edge_o[0], 0);
      chk($sformatf("t3 freq lvl%0d", lv), freq_o[0], 0);
      chk($sformatf("t3 no_sig lvl%0d", lv), nosig_o[0], 1);
      chk($sformatf("t3 ovf lvl%0d", lv), ovf_o[0], 0);
    end

    // Narrow counter saturates at 10 MHz, recovers at 5 MHz
    sig_half_ns = 50;
    repeat (10) @(negedge clk);
    do_start(1, k);
    wait_mv(1, c);
    chk("t4 edge sat", edge_o[1], 31);
    chk("t4 freq sat", freq_o[1], 7);
    chk("t4 ovf sat", ovf_o[1], 1);
    chk("t4 no_sig sat", nosig_o[1], 0);
    sig_half_ns = 100;
    repeat (20) @(negedge clk);
    do_start(1, k);
    wait_mv(1, c);
    chk("t4 ovf clear", ovf_o[1], 0);
    chk_rng("t4 edge 5MHz", edge_o[1], 19, 21);
    chk_rng("t4 freq 5MHz", freq_o[1], 4, 5);

    // Reset mid-window, then start pulses during the gate are ignored
    sig_half_ns = 50;
    repeat (20) @(negedge clk);
    do_start(0, k);
    repeat (200) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5 rst busy", busy_o[0], 0);
    chk("t5 rst mv", mv_o[0], 0);
    chk("t5 rst edge", edge_o[0], 0);
    chk("t5 rst freq", freq_o[0], 0);
    chk("t5 rst no_sig", nosig_o[0], 0);
    chk("t5 rst ovf", ovf_o[0], 0);
    chk("t5 rst ovf1", ovf_o[1], 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    m = mv_cnt[0];
    repeat (600) @(negedge clk);
    chk("t5 no pulse after abort", mv_cnt[0] - m, 0);
    chk("t5 idle", busy_o[0], 0);
    m = mv_cnt[0];
    do_start(0, k);
    repeat (50) @(negedge clk);
    #1 start_r[0] = 1'b1;
    @(negedge clk);
    #1 start_r[0] = 1'b0;
    repeat (100) @(negedge clk);
    #1 start_r[0] = 1'b1;
    @(negedge clk);
    #1 start_r[0] = 1'b0;
    repeat (200) @(negedge clk);
    #1 start_r[0] = 1'b1;
    @(negedge clk);
    #1 start_r[0] = 1'b0;
    wait_mv(0, c);
    chk("t5 latency", c + 1 - k, 401);
    chk_rng("t5 edge_cnt", edge_o[0], 39, 41);
    repeat (500) @(negedge clk);
    chk("t5 pulses", mv_cnt[0] - m, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an asynchronous square-wave input against the system clock and reports it in MHz.
- It is the measurement end of our clock-generation blocks: a generated clock goes in, its frequency comes out as an integer MHz value.
- Counts rising edges of the synchronized input over a fixed gate window of GATE_US microseconds. Divides by GATE_US using a shift.

Parameters:
- CLK_FREQ_MHZ, 100, frequency of clk in MHz. Integer ≥ 2.
- GATE_US, 4, gate window in µs. Must be a power of two (1, 2, 4, …).
- CNT_W, 16, width of the edge counter and result outputs.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sig_in  input  1  measured signal, asynchronous to clk; frequency must be < CLK_FREQ_MHZ/2 MHz
- start  input  1  single-shot request, sampled in IDLE only
- cont_en  input  1  continuous mode; back-to-back measurements while high
- busy  output  1  high in GATE and LATCH
- meas_valid  output  1  one-cycle pulse when results update
- edge_cnt  output  CNT_W  raw rising-edge count of the last window
- freq_mhz  output  CNT_W  edge_cnt >> log2(GATE_US)
- no_sig  output  1  last window counted zero edges
- ovf  output  1  last window saturated the edge counter

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0; gate counter and edge counter are 0; synchronizer flops are 0.
  - Reset asserted mid-window aborts the window with no meas_valid.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer (s1, s2) plus a delay flop s3.
  - rise = s2 & ~s3.
  - A sig_in edge appears on rise 2–3 clk cycles later.
  - The synchronizer runs in all states.
- GATE_CYCLES = CLK_FREQ_MHZ * GATE_US.
- FSM states: IDLE, GATE, LATCH.
- IDLE:
  - busy=0.
  - If start or cont_en is sampled high, go to GATE with gate_cnt=0 and edge counter=0.
- GATE:
  - Lasts exactly GATE_CYCLES cycles.
  - Each cycle with rise=1 increments the edge counter. This includes the first and last gate cycles.
  - The counter saturates at 2^CNT_W−1 and sets an internal overflow flag.
  - On the last gate cycle, go to LATCH.
- LATCH (exactly one cycle):
  - Outputs are registered on entry.
  - meas_valid=1.
  - edge_cnt = final count; freq_mhz = count >> log2(GATE_US), truncating.
  - no_sig = (count==0); ovf = overflow flag.
  - rise in this cycle is not counted (one-cycle dead time).
  - Next state is GATE if cont_en=1, else IDLE.
  - On re-entering GATE, the counters clear.
- Latency:
  - start sampled at edge k.
  - Gate cycles are k+1 … k+GATE_CYCLES.
  - meas_valid is high in cycle k+GATE_CYCLES+1.
  - In continuous mode, meas_valid pulses are spaced GATE_CYCLES+1 cycles apart.
- Result outputs hold their values until the next LATCH. meas_valid is 0 outside LATCH.
- start while busy is ignored; it is not queued.
- start and cont_en together behave as cont_en.
- cont_en dropped mid-window: the current window completes and reports, then the FSM returns to IDLE.
- Accuracy: ±1 edge per window (phase quantization). Resolution is 1/GATE_US MHz before truncation.
- Inputs at or above CLK_FREQ_MHZ/2 produce undefined counts. Verification must not test this range.

Test Plan:
- Defaults (clk 100 MHz, GATE_CYCLES=400); sig_in 10 MHz (100 ns period); single start pulse:
  - Exactly one meas_valid, 401 cycles after the start sample edge.
  - edge_cnt 40±1, freq_mhz 10 (9 allowed only when edge_cnt=39).
  - no_sig=0, ovf=0, busy high for 401 cycles.
- sig_in 25 MHz, cont_en held high for 3 windows:
  - Three meas_valid pulses spaced exactly 401 cycles.
  - Each has edge_cnt 100±1 and freq_mhz 25 (24 allowed when edge_cnt=99).
  - After cont_en drops mid-window, one final pulse follows, then busy=0.
- sig_in held at 1, then held at 0; start each time:
  - edge_cnt=0, freq_mhz=0, no_sig=1, ovf=0.
- CNT_W=5, sig_in 10 MHz, start:
  - edge_cnt=31, freq_mhz=7, ovf=1.
  - Next window at 5 MHz with CNT_W=5 (20 edges): ovf returns to 0.
- Reset and start handling, sig_in 10 MHz:
  - rst_n pulsed low at gate cycle 200: all outputs 0 immediately, no meas_valid, state IDLE.
  - A new start then gives a normal result (edge_cnt 40±1).
  - start pulses during GATE are ignored: only one meas_valid per accepted start.
